// File: rtl/data_selector_scan.sv
// Channel selector with direct or scanning source and a single-entry
// valid/ready output register. Refused requests set a sticky flag.
module data_selector_scan #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 4,
    localparam int unsigned SEL_W   = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [CHANNELS*WIDTH-1:0] c_i,
    input  logic                      req_i,
    output logic [WIDTH-1:0]          y_o,
    output logic [SEL_W-1:0]          y_ch_o,
    output logic                      y_valid_o,
    input  logic                      y_ready_i,
    output logic                      y_last_o,
    output logic                      sel_err_o,
    output logic                      dropped_o
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] y_ch_q, y_ch_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             dropped_q, dropped_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             accept;
    logic [SEL_W-1:0] idx;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;

    // Channel mux; out-of-range indices yield zero.
    always_comb begin
        accept   = req_i & (~valid_q | y_ready_i);
        idx      = mode_i ? ptr_q : sel_i;
        in_range = (32'(idx) < CHANNELS);
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = c_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the output register, scan pointer and drop flag.
    always_comb begin
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        valid_d   = valid_q;
        last_d    = last_q;
        err_d     = err_q;
        dropped_d = dropped_q | (req_i & ~accept);
        ptr_d     = ptr_q;

        if (accept) begin
            y_d     = sel_data;
            y_ch_d  = idx;
            valid_d = 1'b1;
            last_d  = mode_i & (idx == SEL_W'(CHANNELS - 1));
            err_d   = ~mode_i & ~in_range;
        end else if (y_ready_i) begin
            valid_d = 1'b0;
        end

        // Pointer parks at channel 0 whenever direct mode is selected.
        if (!mode_i) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + SEL_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q       <= '0;
            y_ch_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            dropped_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
            dropped_q <= dropped_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y_o       = y_q;
    assign y_ch_o    = y_ch_q;
    assign y_valid_o = valid_q;
    assign y_last_o  = last_q;
    assign sel_err_o = err_q;
    assign dropped_o = dropped_q;

endmodule

// File: tb/tb_data_selector_scan.sv
// Bench for data_selector_scan: a 4-channel instance driven from a vector
// table and a 3-channel instance for the out-of-range select and odd wrap.
module tb_data_selector_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        a_rst, a_mode, a_req, a_ready;
    logic [1:0]  a_sel;
    logic [15:0] a_c;
    logic [3:0]  a_y;
    logic [1:0]  a_ych;
    logic        a_yv, a_last, a_err, a_drop;

    // 3-channel instance
    logic        b_rst, b_mode, b_req, b_ready;
    logic [1:0]  b_sel;
    logic [11:0] b_c;
    logic [3:0]  b_y;
    logic [1:0]  b_ych;
    logic        b_yv, b_last, b_err, b_drop;

    data_selector_scan #(.CHANNELS(4), .WIDTH(4)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .mode_i(a_mode), .sel_i(a_sel), .c_i(a_c),
        .req_i(a_req), .y_o(a_y), .y_ch_o(a_ych), .y_valid_o(a_yv),
        .y_ready_i(a_ready), .y_last_o(a_last), .sel_err_o(a_err), .dropped_o(a_drop)
    );

    data_selector_scan #(.CHANNELS(3), .WIDTH(4)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .mode_i(b_mode), .sel_i(b_sel), .c_i(b_c),
        .req_i(b_req), .y_o(b_y), .y_ch_o(b_ych), .y_valid_o(b_yv),
        .y_ready_i(b_ready), .y_last_o(b_last), .sel_err_o(b_err), .dropped_o(b_drop)
    );

    typedef struct {
        logic [3:0] y;
        logic [1:0] ch;
        logic       last;
        logic       err;
        logic       valid;
        logic       drop;
    } exp_t;

    typedef struct {
        logic [15:0] c;
        logic        mode;
        logic [1:0]  sel;
        logic        req;
        logic        ready;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic cmp_all(input string name, input exp_t e, input logic [3:0] y,
                           input logic [1:0] ch, input logic last, input logic err,
                           input logic valid, input logic drop);
        cmp({name, ".y"}, int'(y), int'(e.y));
        cmp({name, ".y_ch"}, int'(ch), int'(e.ch));
        cmp({name, ".y_last"}, int'(last), int'(e.last));
        cmp({name, ".sel_err"}, int'(err), int'(e.err));
        cmp({name, ".y_valid"}, int'(valid), int'(e.valid));
        cmp({name, ".dropped"}, int'(drop), int'(e.drop));
    endtask

    function automatic exp_t mk_e(input logic [3:0] y, input logic [1:0] ch, input logic last,
                                  input logic err, input logic valid, input logic drop);
        exp_t e;
        e.y = y; e.ch = ch; e.last = last; e.err = err; e.valid = valid; e.drop = drop;
        return e;
    endfunction

    // Drive one cycle on instance A; the expectation goes through the scoreboard.
    task automatic run_a(input string name, input logic [15:0] c, input logic mode,
                         input logic [1:0] sel, input logic req, input logic ready,
                         input exp_t e);
        exp_t got;
        a_c = c; a_mode = mode; a_sel = sel; a_req = req; a_ready = ready;
        sb.push_back(e);
        tick();
        got = sb.pop_front();
        cmp_all(name, got, a_y, a_ych, a_last, a_err, a_yv, a_drop);
    endtask

    task automatic run_b(input string name, input logic [11:0] c, input logic mode,
                         input logic [1:0] sel, input logic req, input logic ready,
                         input exp_t e);
        exp_t got;
        b_c = c; b_mode = mode; b_sel = sel; b_req = req; b_ready = ready;
        sb.push_back(e);
        tick();
        got = sb.pop_front();
        cmp_all(name, got, b_y, b_ych, b_last, b_err, b_yv, b_drop);
    endtask

    task automatic add(input logic [15:0] c, input logic mode, input logic [1:0] sel,
                       input logic req, input logic ready, input exp_t e);
        vec_t v;
        v.c = c; v.mode = mode; v.sel = sel; v.req = req; v.ready = ready; v.e = e;
        vecs.push_back(v);
    endtask

    localparam logic [15:0] CA = 16'h4321;  // c0=1 c1=2 c2=3 c3=4
    localparam logic [11:0] CB = 12'h321;   // c0=1 c1=2 c2=3

    initial begin
        // Direct reads of every channel
        add(CA, 0, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        add(CA, 0, 2'd1, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 0));
        add(CA, 0, 2'd2, 1, 1, mk_e(4'h3, 2'd2, 0, 0, 1, 0));
        add(CA, 0, 2'd3, 1, 1, mk_e(4'h4, 2'd3, 0, 0, 1, 0));
        add(CA, 0, 2'd0, 0, 1, mk_e(4'h4, 2'd3, 0, 0, 0, 0));
        // Scan, req held six cycles, no bubbles
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 0));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h3, 2'd2, 0, 0, 1, 0));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h4, 2'd3, 1, 0, 1, 0));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 0));
        add(CA, 1, 2'd0, 0, 1, mk_e(4'h2, 2'd1, 0, 0, 0, 0));
        // Back-pressure: accept into empty, then three refused cycles with c changing
        add(CA, 1, 2'd0, 1, 0, mk_e(4'h3, 2'd2, 0, 0, 1, 0));
        add(16'hFFFF, 1, 2'd0, 1, 0, mk_e(4'h3, 2'd2, 0, 0, 1, 1));
        add(16'hAAAA, 1, 2'd0, 1, 0, mk_e(4'h3, 2'd2, 0, 0, 1, 1));
        add(16'h5555, 1, 2'd0, 1, 0, mk_e(4'h3, 2'd2, 0, 0, 1, 1));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h4, 2'd3, 1, 0, 1, 1));
        add(CA, 1, 2'd0, 0, 1, mk_e(4'h4, 2'd3, 1, 0, 0, 1));
        // Mode switch restarts scan at channel 0
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 1));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 1));
        add(CA, 0, 2'd2, 0, 1, mk_e(4'h2, 2'd1, 0, 0, 0, 1));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 1));
        add(CA, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 1));
        // Hold a sample (valid=1, scan_ptr=2) ahead of the reset test
        add(CA, 1, 2'd0, 1, 0, mk_e(4'h2, 2'd1, 0, 0, 1, 1));

        a_rst = 1; a_mode = 0; a_sel = 0; a_c = CA; a_req = 0; a_ready = 0;
        b_rst = 1; b_mode = 0; b_sel = 0; b_c = CB; b_req = 0; b_ready = 0;
        tick();
        tick();
        cmp_all("a_reset", mk_e(0, 0, 0, 0, 0, 0), a_y, a_ych, a_last, a_err, a_yv, a_drop);
        cmp_all("b_reset", mk_e(0, 0, 0, 0, 0, 0), b_y, b_ych, b_last, b_err, b_yv, b_drop);
        a_rst = 0;
        b_rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_a($sformatf("vec%0d", i), vecs[i].c, vecs[i].mode, vecs[i].sel,
                  vecs[i].req, vecs[i].ready, vecs[i].e);
        end

        // Reset dominates req/ready/mode mid-transfer
        a_rst = 1;
        run_a("rst_mid", CA, 1, 2'd0, 1, 1, mk_e(0, 0, 0, 0, 0, 0));
        a_rst = 0;
        run_a("rst_scan0", CA, 1, 2'd0, 1, 0, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        // Input changes without accept leave outputs alone
        run_a("noacc_hold", 16'hFFFF, 0, 2'd3, 0, 0, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        run_a("consume", 16'hFFFF, 0, 2'd3, 0, 1, mk_e(4'h1, 2'd0, 0, 0, 0, 0));
        run_a("direct_ff", 16'hFFFF, 0, 2'd3, 1, 1, mk_e(4'hF, 2'd3, 0, 0, 1, 0));

        // Three channels: out-of-range select, recovery, scan wrap at 2
        run_b("b_oor", CB, 0, 2'd3, 1, 1, mk_e(4'h0, 2'd3, 0, 1, 1, 0));
        run_b("b_sel1", CB, 0, 2'd1, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 0));
        run_b("b_scan0", CB, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        run_b("b_scan1", CB, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 0));
        run_b("b_scan2", CB, 1, 2'd0, 1, 1, mk_e(4'h3, 2'd2, 1, 0, 1, 0));
        run_b("b_wrap", CB, 1, 2'd0, 1, 1, mk_e(4'h1, 2'd0, 0, 0, 1, 0));
        run_b("b_refuse", CB, 1, 2'd0, 1, 0, mk_e(4'h1, 2'd0, 0, 0, 1, 1));
        run_b("b_after", CB, 1, 2'd0, 1, 1, mk_e(4'h2, 2'd1, 0, 0, 1, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_selector_scan.md
DATA_SELECTOR_SCAN -- requirements
Module: data_selector_scan

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL be the number of selectable input channels (legal range 2..16).
REQ-002 Parameter WIDTH, default 4, SHALL be the bit width of each channel (legal range 1..32).
REQ-003 Derived localparam SEL_W SHALL equal max(1, clog2(CHANNELS)).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 mode  input  1  SHALL select the channel source: 0 = direct (sel), 1 = scan (internal pointer).
REQ-007 sel  input  SEL_W  SHALL be the channel index used in direct mode.
REQ-008 c  input  CHANNELS*WIDTH  SHALL carry all channels packed; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 req  input  1  SHALL request one sample capture in the current cycle.
REQ-010 y  output  WIDTH  SHALL be the registered selected data.
REQ-011 y_ch  output  SEL_W  SHALL be the channel index captured with y.
REQ-012 y_valid  output  1  SHALL indicate y/y_ch hold an unconsumed sample.
REQ-013 y_ready  input  1  SHALL indicate the consumer takes the sample when y_valid=1.
REQ-014 y_last  output  1  SHALL flag that the held sample is channel CHANNELS-1 captured in scan mode.
REQ-015 sel_err  output  1  SHALL flag that the held sample came from an out-of-range direct sel.
REQ-016 dropped  output  1  SHALL be a sticky flag that at least one req was refused.

Function
REQ-017 Accept condition SHALL be: req=1 AND (y_valid=0 OR y_ready=1).
REQ-018 On accept, idx SHALL be sel if mode=0, else scan_ptr; y, y_ch, y_last, sel_err SHALL load on that edge and y_valid SHALL become 1 (latency 1 cycle from req to y_valid).
REQ-019 On accept with idx < CHANNELS, y SHALL load c[idx*WIDTH +: WIDTH] as sampled at that edge.
REQ-020 On accept in direct mode with sel >= CHANNELS (non-power-of-2 CHANNELS only), y SHALL load 0, y_ch SHALL load sel, sel_err SHALL load 1; otherwise sel_err SHALL load 0.
REQ-021 y_last SHALL load 1 only when mode=1 and idx = CHANNELS-1; otherwise 0.
REQ-022 scan_ptr (SEL_W bits, internal) SHALL increment on each accept in scan mode, wrapping from CHANNELS-1 to 0.
REQ-023 scan_ptr SHALL be held at 0 on every cycle with mode=0, so each entry to scan mode begins at channel 0.
REQ-024 If y_valid=1, y_ready=1 and no accept, y_valid SHALL go to 0 next cycle; y, y_ch, y_last, sel_err SHALL hold their values.
REQ-025 Simultaneous consume and accept (y_valid=1, y_ready=1, req=1) SHALL replace the sample with no bubble; y_valid stays 1.
REQ-026 If y_valid=1 and y_ready=0, outputs SHALL hold stable; a req in that cycle SHALL be refused, SHALL NOT advance scan_ptr, and SHALL set dropped=1.
REQ-027 Changes on c, sel or mode without an accept SHALL NOT alter y, y_ch, y_last or sel_err.

Reset
REQ-028 While rst=1 at a rising edge: y=0, y_ch=0, y_valid=0, y_last=0, sel_err=0, dropped=0, scan_ptr=0.
REQ-029 rst SHALL dominate req, y_ready and mode in the same cycle; a held sample is discarded when reset arrives mid-transfer.
REQ-030 dropped SHALL clear only through rst.

Verification
REQ-031 Direct, CHANNELS=4, WIDTH=4, c0..c3=0001,0010,0011,0100, y_ready=1, req pulsed with sel=00,01,10,11 -> y=0001,0010,0011,0100 one cycle after each req, y_ch matching, y_last=0.
REQ-032 Scan, same data, req held high 6 cycles, y_ready=1 -> y sequence 0001,0010,0011,0100,0001,0010; y_last=1 only on 0100; back-to-back y_valid=1 without bubble.
REQ-033 Back-pressure: sample held with y_ready=0 for 3 cycles while req=1 and c changes -> y unchanged, scan_ptr unchanged, dropped=1 from the first refused cycle until rst.
REQ-034 CHANNELS=3, direct sel=11, req -> y=0000, y_ch=11, sel_err=1; next req with sel=01 -> y=c1, sel_err=0.
REQ-035 Mode switch: scan advanced to channel 2, mode=0 for one cycle, then scan req -> y=c0, y_ch=0.
REQ-036 rst asserted with y_valid=1, dropped=1, scan_ptr=2 -> next cycle all outputs 0, and first scan accept after release yields channel 0.
